// File: rtl/serial_alu_sequencer.sv
// Bit-serial 32-bit ALU: one result bit per clock, LSB first, with a
// post-pass fix-up cycle that turns the sign information into the SLT result.
module serial_alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  ctrl_q;
  logic [4:0]  idx;
  logic        cin;
  logic        set_q;
  logic        ovf_q;
  logic [31:0] res_q;

  logic        a_bit;
  logic        b_bit;
  logic        ai;
  logic        bi;
  logic        sum;
  logic        cout;
  logic        bit_res;
  logic        set_val;
  logic        last_bit;

  assign a_bit    = a_q[idx];
  assign b_bit    = b_q[idx];
  assign ai       = a_bit ^ ctrl_q[3];
  assign bi       = b_bit ^ ctrl_q[2];
  assign sum      = ai ^ bi ^ cin;
  assign cout     = (ai & bi) | (ai & cin) | (bi & cin);
  assign last_bit = (idx == 5'd31);

  always_comb begin
    bit_res = 1'b0;
    case (ctrl_q[1:0])
      2'b00:   bit_res = ai & bi;
      2'b01:   bit_res = ai | bi;
      2'b10:   bit_res = sum;
      default: bit_res = 1'b0;
    endcase
  end

  // Differing sign bits decide SLT directly; equal signs defer to the difference sign.
  always_comb begin
    set_val = sum;
    if (a_bit && !b_bit)
      set_val = 1'b1;
    else if (!a_bit && b_bit)
      set_val = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start)
          state_next = RUN;
      end
      RUN: begin
        if (last_bit)
          state_next = (ctrl_q[1:0] == 2'b11) ? FIX : DONE;
      end
      FIX: state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      idx    <= '0;
      cin    <= 1'b0;
      set_q  <= 1'b0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= src_a;
            b_q    <= src_b;
            ctrl_q <= alu_ctrl;
            idx    <= '0;
            cin    <= alu_ctrl[2];
            set_q  <= 1'b0;
            ovf_q  <= 1'b0;
            res_q  <= '0;
          end
        end
        RUN: begin
          res_q[idx] <= bit_res;
          cin        <= cout;
          idx        <= idx + 5'd1;
          if (last_bit) begin
            set_q <= set_val;
            ovf_q <= (ctrl_q[1:0] == 2'b10) ? (cin ^ cout) : 1'b0;
          end
        end
        FIX: res_q <= {31'b0, set_q};
        default: ;
      endcase
    end
  end

  assign result   = res_q;
  assign zero     = (res_q == 32'b0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Randomized self-checking bench for serial_alu_sequencer against a
// word-level arithmetic reference model.
module tb_serial_alu_sequencer;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  serial_alu_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word-level reference: invert operands, do one 33-bit addition, pick by op.
  function automatic void refModel(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic ovf, output int lat);
    logic [31:0] ax;
    logic [31:0] bx;
    logic [32:0] full;
    ax   = ctrl[3] ? ~a : a;
    bx   = ctrl[2] ? ~b : b;
    full = {1'b0, ax} + {1'b0, bx} + {32'b0, ctrl[2]};
    ovf  = 1'b0;
    lat  = 33;
    case (ctrl[1:0])
      2'b00: res = ax & bx;
      2'b01: res = ax | bx;
      2'b10: begin
        res = full[31:0];
        ovf = (ax[31] == bx[31]) && (full[31] != ax[31]);
      end
      default: begin
        lat = 34;
        if (a[31] && !b[31])      res = 32'd1;
        else if (!a[31] && b[31]) res = 32'd0;
        else                      res = {31'b0, full[31]};
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               input bit pulseMid, input string tag);
    logic [31:0] expRes;
    logic        expOvf;
    int          expLat;
    int          waitN;
    int          cyc;
    refModel(ctrl, a, b, expRes, expOvf, expLat);
    waitN = 0;
    while (!ready && waitN < 100) begin
      @(negedge clk);
      waitN++;
    end
    checkOutput({tag, "/ready"}, {31'b0, ready}, 32'd1);
    alu_ctrl = ctrl;
    src_a    = a;
    src_b    = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "/accepted"}, {31'b0, ready}, 32'd0);
    src_a    = $urandom;
    src_b    = $urandom;
    alu_ctrl = 4'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (pulseMid && cyc == 15);
    end while (!done && cyc < 60);
    start = 1'b0;
    checkOutput({tag, "/latency"}, cyc, expLat);
    checkOutput({tag, "/result"}, result, expRes);
    checkOutput({tag, "/zero"}, {31'b0, zero}, {31'b0, expRes == 32'b0});
    checkOutput({tag, "/overflow"}, {31'b0, overflow}, {31'b0, expOvf});
    @(negedge clk);
    checkOutput({tag, "/hold"}, result, expRes);
    checkOutput({tag, "/doneLow"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [3:0]  ctrlList [6];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rc;
    logic [31:0] expRes;
    logic        expOvf;
    int          expLat;
    int          cyc;
    int          doneCount;
    int          firstDone;

    ctrlList = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};

    rst      = 1'b1;
    start    = 1'b0;
    alu_ctrl = '0;
    src_a    = '0;
    src_b    = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset/ready", {31'b0, ready}, 32'd1);
    checkOutput("reset/done", {31'b0, done}, 32'd0);
    checkOutput("reset/result", result, 32'd0);
    checkOutput("reset/zero", {31'b0, zero}, 32'd1);
    checkOutput("reset/overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;

    applyStimulus(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, "addOvf");
    applyStimulus(OP_SUB, 32'h00000005, 32'h00000005, 1'b0, "subZero");
    applyStimulus(OP_SLT, 32'hFFFFFFFF, 32'h00000001, 1'b0, "sltNeg");
    applyStimulus(OP_SLT, 32'h00000001, 32'hFFFFFFFF, 1'b0, "sltPos");
    applyStimulus(OP_NOR, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, "nor");
    applyStimulus(OP_AND, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, "and");
    applyStimulus(OP_OR,  32'hF0F0F0F0, 32'h0F0F0000, 1'b0, "or");
    applyStimulus(OP_ADD, 32'h12345678, 32'h0FEDCBA9, 1'b1, "midStart");

    // Abort an ADD after ten bits have been processed.
    @(negedge clk);
    alu_ctrl = OP_ADD;
    src_a    = 32'h0000FFFF;
    src_b    = 32'h00000F0F;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort/ready", {31'b0, ready}, 32'd1);
    checkOutput("abort/result", result, 32'd0);
    checkOutput("abort/zero", {31'b0, zero}, 32'd1);
    checkOutput("abort/done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort/noDone", doneCount, 32'd0);
    applyStimulus(OP_ADD, 32'h0000FFFF, 32'h00000F0F, 1'b0, "afterAbort");

    // Two back-to-back SUBs with start held high; src_a changes during the first.
    @(negedge clk);
    alu_ctrl = OP_SUB;
    src_a    = 32'h00001000;
    src_b    = 32'h00000234;
    start    = 1'b1;
    @(posedge clk);
    #1;
    src_a = 32'h80000000;
    cyc = 0;
    doneCount = 0;
    firstDone = 0;
    while (doneCount < 2 && cyc < 120) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        doneCount++;
        if (doneCount == 1) begin
          firstDone = cyc;
          refModel(OP_SUB, 32'h00001000, 32'h00000234, expRes, expOvf, expLat);
          checkOutput("b2b/first", result, expRes);
        end else begin
          start = 1'b0;
          checkOutput("b2b/gap", cyc - firstDone, 32'd34);
          refModel(OP_SUB, 32'h80000000, 32'h00000234, expRes, expOvf, expLat);
          checkOutput("b2b/second", result, expRes);
          checkOutput("b2b/secondOvf", {31'b0, overflow}, {31'b0, expOvf});
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b/count", doneCount, 32'd2);
    checkOutput("b2b/firstLat", firstDone, 32'd33);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h0;
        1:       ra = 32'hFFFFFFFF;
        2:       ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 32'h7FFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0)
        rc = 4'($urandom);
      else
        rc = ctrlList[$urandom_range(0, 5)];
      applyStimulus(rc, ra, rb, ($urandom_range(0, 3) == 0), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_alu_sequencer.md
SERIAL_ALU_SEQUENCER -- requirements
Module: serial_alu_sequencer

Interface
REQ-001 The block SHALL have these ports; clock and reset come first:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only when ready=1.
- alu_ctrl  in  4  {a_invert, b_invert, operation[1:0]}. Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- src_a  in  32  operand A.
- src_b  in  32  operand B.
- ready  out  1  idle and able to accept a request.
- done  out  1  one-cycle pulse; result and flags are valid in that cycle.
- result  out  32  computed word.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow for ADD and SUB; 0 for all other operations.
REQ-002 The block SHALL have no parameters. Width is fixed at 32 bits.

Function
REQ-003 The block SHALL compute the word one bit per cycle, LSB first. Each cycle applies the per-bit rules below to bit i, the latched carry and the latched controls.
- ai = a_i ^ a_invert; bi = b_i ^ b_invert.
- sum = ai ^ bi ^ cin.
- cout = ai&bi | ai&cin | bi&cin.
- Per-bit result: op 00 gives ai&bi, op 01 gives ai|bi, op 10 gives sum, op 11 gives 0 (the less input is tied to 0 for bits 1..31).
REQ-004 State machine states are IDLE, RUN, FIX and DONE. The state SHALL be encoded in at most 2 bits.
REQ-005 IDLE:
- ready = 1.
- On start=1, latch src_a, src_b and alu_ctrl, clear the result shift register, set the bit index to 0, set cin = b_invert, then go to RUN.
- start=0 keeps the block in IDLE.
REQ-006 RUN:
- Process bit[index] each cycle, store the per-bit result into result[index], set cin to cout, and increment index.
- After bit 31, go to FIX if op = 11, otherwise go to DONE.
REQ-007 At bit 31 the block SHALL capture the set value.
- a31=1 and b31=0: set = 1.
- a31=0 and b31=1: set = 0.
- Otherwise: set = sum.
- set uses the raw operand bits, not the inverted ones.
REQ-008 Also at bit 31, overflow SHALL be captured as cin ^ cout when op = 10, and as 0 otherwise.
REQ-009 FIX SHALL last one cycle. It writes result[0] = set; result[31:1] stay 0. The next state is DONE.
REQ-010 DONE SHALL last one cycle.
- done = 1 and ready = 0.
- result, zero and overflow are valid.
- Next state is IDLE.
REQ-011 result, zero and overflow SHALL hold their values after DONE until the next accepted start.
REQ-012 Latency from the start-accept edge to the done cycle SHALL be 33 cycles for non-SLT operations and 34 cycles for SLT.
REQ-013 While the state is not IDLE, ready = 0 and start SHALL be ignored. Changes on src_a, src_b and alu_ctrl after acceptance SHALL NOT affect the result.
REQ-014 Unsupported alu_ctrl codes SHALL be executed using their raw field values under the REQ-003 rules, with no error indication.
REQ-015 start held high continuously SHALL be accepted again in the IDLE cycle that follows DONE, giving back-to-back operations with one idle cycle between them.

Reset
REQ-016 While rst=1, asynchronously and independent of clk, the block SHALL set:
- state = IDLE, ready = 1, done = 0.
- result = 0, zero = 1, overflow = 0.
- index, carry and all latched operands and controls = 0.
REQ-017 Reset asserted during RUN or FIX SHALL abort the operation without producing a done pulse.
REQ-018 The first start SHALL be accepted on the first rising clk edge after rst is deasserted.

Verification
REQ-019 ADD, src_a=0x7FFFFFFF, src_b=0x00000001 -> done 33 cycles after accept; result=0x80000000, overflow=1, zero=0.
REQ-020 SUB, src_a=0x00000005, src_b=0x00000005 -> result=0x00000000, zero=1, overflow=0.
REQ-021 SLT:
- src_a=0xFFFFFFFF (-1), src_b=0x00000001 -> result=0x00000001, with done 34 cycles after accept.
- Swapped operands -> result=0x00000000.
REQ-022 NOR, src_a=0xF0F0F0F0, src_b=0x0F0F0000 -> result=0x00000F0F, overflow=0. Also an AND/OR pair on the same operands -> 0x00000000 and 0xFFFFF0F0.
REQ-023 Reset and busy handling:
- Assert rst at bit index 10 of an ADD -> no done pulse; ready=1 and result=0 at once; a following start completes normally.
- Pulse start mid-RUN -> the pulse is ignored.
REQ-024 start held high across two SUB operations -> two done pulses exactly 34 cycles apart. Changing src_a during the first RUN does not change the first result.
